// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-datapath control unit: opcodes, FSM states,
// the strobe bundle and the per-opcode last execute step.
package cpu_pkg;

  localparam int OPW = 5;
  localparam int DW  = 32;

  localparam logic [OPW-1:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [OPW-1:0] OP_ADD  = 5'd3,  OP_SHL  = 5'd11;
  localparam logic [OPW-1:0] OP_ADDI = 5'd12, OP_ORI  = 5'd14;
  localparam logic [OPW-1:0] OP_DIV  = 5'd15, OP_MUL  = 5'd16;
  localparam logic [OPW-1:0] OP_NEG  = 5'd17, OP_NOT  = 5'd18;
  localparam logic [OPW-1:0] OP_BR   = 5'd19, OP_JAL  = 5'd20, OP_JR   = 5'd21;
  localparam logic [OPW-1:0] OP_IN   = 5'd22, OP_OUT  = 5'd23;
  localparam logic [OPW-1:0] OP_MFLO = 5'd24, OP_MFHI = 5'd25;
  localparam logic [OPW-1:0] OP_NOP  = 5'd26, OP_HALT = 5'd27;
  localparam logic [OPW-1:0] ALU_ADD = 5'd3;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef struct packed {
    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin;
    logic Gra, Grb, Grc, Read, IncPC, RAM_write_en, enableOutputPort;
  } ctrl_t;

  function automatic state_t last_step(input logic [OPW-1:0] op);
    if (op == OP_LD || op == OP_ST)                     return S_T7;
    if (op == OP_DIV || op == OP_MUL || op == OP_BR)    return S_T6;
    if (op == OP_LDI || (op >= OP_ADD && op <= OP_ORI)) return S_T5;
    if (op == OP_NEG || op == OP_NOT || op == OP_JAL)   return S_T4;
    return S_T3;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/condition/stop feedback in, strobes out.
interface control_unit_if;
  import cpu_pkg::*;

  logic [DW-1:0]  ir;
  logic           con_ff, stop, run;
  logic [OPW-1:0] alu_op;
  logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin;
  logic Gra, Grb, Grc, Read, IncPC, RAM_write_en, enableOutputPort;

  modport master (
    input  ir, con_ff, stop,
    output run, alu_op,
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin,
    output Gra, Grb, Grc, Read, IncPC, RAM_write_en, enableOutputPort
  );

  modport slave (
    output ir, con_ff, stop,
    input  run, alu_op,
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin,
    input  Gra, Grb, Grc, Read, IncPC, RAM_write_en, enableOutputPort
  );
endinterface

// File: rtl/control_unit.sv
// Moore sequencer for the bus datapath: fetch T0-T2, decode IR[31:27], execute T3-T7.
// Strobes decode from the registered step and ir, so clear zeroes them immediately.
module control_unit
  import cpu_pkg::*;
(
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master bus
);

  state_t         state_q;
  logic           paused_q;
  logic [OPW-1:0] op;
  logic [OPW-1:0] alu;
  ctrl_t          c;
  logic           unused_ir;

  assign op        = bus.ir[DW-1 -: OPW];
  assign unused_ir = ^bus.ir[DW-OPW-1:0];

  // stop is captured on every edge that lands in T0, so a paused T0 never
  // issues IncPC and the first live T0 after stop drops fetches exactly once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= S_RST;
      paused_q <= 1'b0;
    end else begin
      case (state_q)
        S_RST:  begin state_q <= S_T0; paused_q <= bus.stop; end
        S_T0:   if (paused_q) paused_q <= bus.stop;
                else          state_q  <= S_T1;
        S_T1:   state_q <= S_T2;
        S_T2:   state_q <= S_T3;
        S_HALT: state_q <= S_HALT;
        default:
          if (state_q == S_T3 && op == OP_HALT) state_q <= S_HALT;
          else if (state_q == last_step(op)) begin
            state_q  <= S_T0;
            paused_q <= bus.stop;
          end else state_q <= state_q.next();
      endcase
    end
  end

  always_comb begin
    c   = '0;
    alu = '0;
    case (state_q)
      S_T0: if (!paused_q) begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; end
      S_T1: begin c.Zlowout = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
      S_T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        alu = op;
        case (op) inside
          OP_LD, OP_LDI, OP_ST:
            case (state_q)
              S_T3: begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
              S_T4: begin c.Cout = 1'b1; c.Zin = 1'b1; alu = ALU_ADD; end
              S_T5: begin
                c.Zlowout = 1'b1;
                if (op == OP_LDI) begin c.Gra = 1'b1; c.Rin = 1'b1; end
                else c.MARin = 1'b1;
              end
              S_T6: if (op == OP_LD) begin c.Read = 1'b1; c.MDRin = 1'b1; end
                    else if (op == OP_ST) begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; end
              S_T7: if (op == OP_LD) begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
                    else if (op == OP_ST) c.RAM_write_en = 1'b1;
              default: ;
            endcase
          [OP_ADD:OP_ORI]:
            case (state_q)
              S_T3: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
              S_T4: begin
                c.Zin = 1'b1;
                if (op <= OP_SHL) begin c.Grc = 1'b1; c.Rout = 1'b1; end
                else c.Cout = 1'b1;
              end
              S_T5: begin c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
              default: ;
            endcase
          OP_DIV, OP_MUL:
            case (state_q)
              S_T3: begin c.Gra = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
              S_T4: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; end
              S_T5: begin c.Zlowout = 1'b1; c.LOin = 1'b1; end
              S_T6: begin c.Zhighout = 1'b1; c.HIin = 1'b1; end
              default: ;
            endcase
          OP_NEG, OP_NOT:
            case (state_q)
              S_T3: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; end
              S_T4: begin c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
              default: ;
            endcase
          OP_BR:
            case (state_q)
              S_T3: begin c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1; end
              S_T4: begin c.PCout = 1'b1; c.Yin = 1'b1; end
              S_T5: begin c.Cout = 1'b1; c.Zin = 1'b1; alu = ALU_ADD; end
              S_T6: if (bus.con_ff) begin c.Zlowout = 1'b1; c.PCin = 1'b1; end
              default: ;
            endcase
          OP_JAL:
            case (state_q)
              S_T3: begin c.PCout = 1'b1; c.Grb = 1'b1; c.Rin = 1'b1; end
              S_T4: begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
              default: ;
            endcase
          OP_JR:   if (state_q == S_T3) begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
          OP_IN:   if (state_q == S_T3) begin c.InPortout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          OP_OUT:  if (state_q == S_T3) begin c.Gra = 1'b1; c.Rout = 1'b1; c.enableOutputPort = 1'b1; end
          OP_MFLO: if (state_q == S_T3) begin c.LOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          OP_MFHI: if (state_q == S_T3) begin c.HIout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.run    = (state_q != S_HALT);
  assign bus.alu_op = alu;
  assign {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.HIout, bus.LOout,
          bus.InPortout, bus.Cout, bus.Rout, bus.BAout,
          bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin, bus.Zin, bus.HIin,
          bus.LOin, bus.Rin, bus.CONin,
          bus.Gra, bus.Grb, bus.Grc, bus.Read, bus.IncPC, bus.RAM_write_en,
          bus.enableOutputPort} = c;

endmodule
